button_event_arbiter: RTL and testbench

Debounces and serializes a bank of asynchronous push-button inputs into a single event stream. Each raw input passes through a reset-able multi-stage synchronizer and a per-channel debounce counter. Debounced transitions are queued as per-channel pending events, and a round-robin arbiter emits them one at a time over a valid/ready handshake. It sits between board-level button pins and the front-panel/command logic.

---
 rtl/button_event_arbiter.sv | 150 +++++++++++++++
 tb/tb_button_event_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
`default_nettype none
// button_event_arbiter: synchronizes, debounces and round-robin serializes button events (rev 1.0).
// Define BUTTON_RELEASE_EVT_EN to also report release transitions.
module button_event_arbiter #(
  parameter int WIDTH           = 4,
  parameter int STAGES          = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         btn_in,
  output logic [WIDTH-1:0]         level,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(WIDTH)-1:0] evt_id,
  output logic                     evt_press,
  output logic                     evt_overflow
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];
  logic [WIDTH-1:0] level_q, level_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] pend_v_q, pend_v_d, pend_p_q, pend_p_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic             evt_valid_q, evt_valid_d;
  logic [IW-1:0]    evt_id_q, evt_id_d;
  logic             evt_press_q, evt_press_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] raise, pol;
  logic             load, found, grant;
  logic [IW-1:0]    grant_idx;
  int               idx;

  always_comb begin
    sync_d[0] = btn_in;
    for (int s = 1; s < STAGES; s++) sync_d[s] = sync_q[s-1];
  end

  // A channel flips only after the synchronized value disagrees for DEBOUNCE_CYCLES edges.
  always_comb begin
    level_d = level_q;
    raise   = '0;
    pol     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_q[STAGES-1][i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = sync_q[STAGES-1][i];
          pol[i]     = sync_q[STAGES-1][i];
`ifdef BUTTON_RELEASE_EVT_EN
          raise[i]   = 1'b1;
`else
          raise[i]   = sync_q[STAGES-1][i];
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    load      = !evt_valid_q || evt_ready;
    found     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < WIDTH; k++) begin
      idx = (int'(ptr_q) + k) % WIDTH;
      if (!found && pend_v_q[idx]) begin
        found     = 1'b1;
        grant_idx = IW'(idx);
      end
    end
    grant = load && found;
  end

  // The granted entry is cleared first so a raise on the same edge refills it legally.
  always_comb begin
    pend_v_d = pend_v_q;
    pend_p_d = pend_p_q;
    ovf_d    = ovf_q;
    if (grant) pend_v_d[grant_idx] = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (raise[i]) begin
        if (pend_v_d[i]) begin
          ovf_d = 1'b1;
        end else begin
          pend_v_d[i] = 1'b1;
          pend_p_d[i] = pol[i];
        end
      end
    end
  end

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    evt_press_d = evt_press_q;
    ptr_d       = ptr_q;
    if (load) begin
      evt_valid_d = found;
      if (found) begin
        evt_id_d    = grant_idx;
        evt_press_d = pend_p_q[grant_idx];
        ptr_d       = (grant_idx == IW'(WIDTH - 1)) ? '0 : grant_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      level_q     <= '0;
      pend_v_q    <= '0;
      pend_p_q    <= '0;
      ptr_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_press_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      for (int s = 0; s < STAGES; s++) sync_q[s] <= sync_d[s];
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      level_q     <= level_d;
      pend_v_q    <= pend_v_d;
      pend_p_q    <= pend_p_d;
      ptr_q       <= ptr_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      evt_press_q <= evt_press_d;
      ovf_q       <= ovf_d;
    end
  end

  assign level        = level_q;
  assign evt_valid    = evt_valid_q;
  assign evt_id       = evt_id_q;
  assign evt_press    = evt_press_q;
  assign evt_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_button_event_arbiter.sv
`default_nettype none
// tb_button_event_arbiter: directed and random stimulus against a queue-based reference model.
module tb_button_event_arbiter;

  localparam int WIDTH = 4;
  localparam int STAGES = 2;
  localparam int DEB = 16;
  localparam int IW = $clog2(WIDTH);
`ifdef BUTTON_RELEASE_EVT_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] btn_in = '0;
  logic [WIDTH-1:0] level;
  logic             evt_valid;
  logic             evt_ready = 1'b1;
  logic [IW-1:0]    evt_id;
  logic             evt_press;
  logic             evt_overflow;

  button_event_arbiter #(.WIDTH(WIDTH), .STAGES(STAGES), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .level(level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_press(evt_press), .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: delayed samples, disagreement run lengths, pending table, output slot.
  typedef struct { int id; bit press; } ev_t;
  ev_t              exp_q[$];
  logic [WIDTH-1:0] m_hist[$];
  bit   [WIDTH-1:0] m_level;
  int               m_run[WIDTH];
  bit               m_pv[WIDTH];
  bit               m_pp[WIDTH];
  int               m_ptr;
  bit               m_ov;
  int               m_oid;
  bit               m_op;
  bit               m_ovf;

  task automatic m_reset();
    m_hist.delete();
    for (int s = 0; s < STAGES; s++) m_hist.push_back('0);
    m_level = '0;
    for (int i = 0; i < WIDTH; i++) begin m_run[i] = 0; m_pv[i] = 0; m_pp[i] = 0; end
    m_ptr = 0; m_ov = 0; m_oid = 0; m_op = 0; m_ovf = 0;
    exp_q.delete();
  endtask

  task automatic m_step();
    logic [WIDTH-1:0] s;
    bit   [WIDTH-1:0] new_level;
    bit   [WIDTH-1:0] rse;
    bit   [WIDTH-1:0] rpol;
    int g;
    s = m_hist.pop_front();
    m_hist.push_back(btn_in);
    new_level = m_level;
    rse = '0;
    rpol = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          new_level[i] = s[i];
          m_run[i] = 0;
          rse[i] = REL || s[i];
          rpol[i] = s[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    if (!m_ov || evt_ready) begin
      g = -1;
      for (int k = 0; k < WIDTH; k++)
        if (g < 0 && m_pv[(m_ptr + k) % WIDTH]) g = (m_ptr + k) % WIDTH;
      if (g >= 0) begin
        m_ov = 1; m_oid = g; m_op = m_pp[g]; m_pv[g] = 0;
        m_ptr = (g + 1) % WIDTH;
        exp_q.push_back('{id: g, press: m_pp[g]});
      end else begin
        m_ov = 0;
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (rse[i]) begin
        if (m_pv[i]) m_ovf = 1;
        else begin m_pv[i] = 1; m_pp[i] = rpol[i]; end
      end
    end
    m_level = new_level;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else m_step();
  end

  // Monitor: compares visible state every cycle and pops the scoreboard on each transfer.
  int n_acc = 0;
  int acc_ids[$];
  bit acc_press[$];
  ev_t e;

  always @(negedge clk) begin
    check("level", int'(level), int'(m_level));
    check("evt_valid", int'(evt_valid), int'(m_ov));
    check("evt_overflow", int'(evt_overflow), int'(m_ovf));
    if (m_ov) begin
      check("evt_id_held", int'(evt_id), m_oid);
      check("evt_press_held", int'(evt_press), int'(m_op));
    end
    if (evt_valid && evt_ready && rst_n) begin
      n_acc++;
      acc_ids.push_back(int'(evt_id));
      acc_press.push_back(evt_press);
      if (exp_q.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_id", int'(evt_id), e.id);
        check("sb_press", int'(evt_press), int'(e.press));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!evt_valid && k < 60) begin step(); k++; end
    check(name, int'(evt_valid), 1);
  endtask

  int n0;

  initial begin
    // Reset with all buttons held, then press latency and in-order drain.
    btn_in = 4'b1111;
    evt_ready = 1'b1;
    repeat (3) step();
    check("rst_level", int'(level), 0);
    check("rst_valid", int'(evt_valid), 0);
    check("rst_id", int'(evt_id), 0);
    check("rst_press", int'(evt_press), 0);
    check("rst_overflow", int'(evt_overflow), 0);
    rst_n = 1'b1;
    repeat (17) step();
    check("level_edge17", int'(level), 0);
    step();
    check("level_edge18", int'(level), 15);
    check("valid_edge18", int'(evt_valid), 0);
    for (int k = 0; k < WIDTH; k++) begin
      step();
      check("drain_valid", int'(evt_valid), 1);
      check("drain_id", int'(evt_id), k);
    end
    step();
    check("drain_done", int'(evt_valid), 0);
    btn_in = '0;
    repeat (40) step();

    // Glitch shorter than the debounce window.
    n0 = n_acc;
    btn_in[2] = 1'b1;
    repeat (10) step();
    btn_in[2] = 1'b0;
    repeat (40) step();
    check("glitch_level", int'(level[2]), 0);
    check("glitch_no_event", n_acc, n0);

    // Backpressure holds the event stable.
    evt_ready = 1'b0;
    btn_in[1] = 1'b1;
    wait_valid("bp_wait_valid");
    for (int k = 0; k < 20; k++) begin
      step();
      check("bp_valid", int'(evt_valid), 1);
      check("bp_id", int'(evt_id), 1);
    end
    evt_ready = 1'b1;
    step();
    check("bp_released", int'(evt_valid), 0);
    btn_in[1] = 1'b0;
    repeat (40) step();

    // Round robin: leave ptr at 1, then raise ch0 and ch3 together.
    btn_in[0] = 1'b1;
    repeat (40) step();
    btn_in[0] = 1'b0;
    repeat (40) step();
    acc_ids.delete();
    btn_in = 4'b1001;
    repeat (40) step();
    check("rr_count", acc_ids.size(), 2);
    if (acc_ids.size() == 2) begin
      check("rr_first", acc_ids[0], 3);
      check("rr_second", acc_ids[1], 0);
    end
    check("rr_no_overflow", int'(evt_overflow), 0);
    btn_in = '0;
    repeat (40) step();

    // Reset in the middle of a held transfer.
    evt_ready = 1'b0;
    btn_in[1] = 1'b1;
    wait_valid("mid_wait_valid");
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(evt_valid), 0);
    btn_in = '0;
    step();
    rst_n = 1'b1;
    evt_ready = 1'b1;
    n0 = n_acc;
    repeat (40) step();
    check("mid_rst_no_stale", n_acc, n0);

    // Press, release, press with a stalled consumer.
    evt_ready = 1'b0;
    btn_in[0] = 1'b1;
    repeat (25) step();
    btn_in[0] = 1'b0;
    repeat (25) step();
    btn_in[0] = 1'b1;
    repeat (25) step();
    check("ovf_flag", int'(evt_overflow), int'(REL));
    acc_press.delete();
    evt_ready = 1'b1;
    repeat (10) step();
    check("ovf_delivered", acc_press.size(), 2);
    if (acc_press.size() > 0) check("ovf_first_press", int'(acc_press[0]), 1);
    btn_in = '0;
    repeat (40) step();

    // Random buttons and random backpressure.
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < WIDTH; i++)
        if ($urandom_range(0, 24) == 0) btn_in[i] = ~btn_in[i];
      evt_ready = ($urandom_range(0, 3) != 0);
    end
    evt_ready = 1'b1;
    repeat (60) step();
    check("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
